// File: rtl/disp_scan.sv
// disp_scan: double-buffered, time-multiplexed seven-segment scan driver.
// Optional feature: define DISP_LZ_BLANK_EN to enable leading-zero blanking.
module disp_scan #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] num,
  input  logic [2:0]          dp,
  input  logic                blank,
  output logic                ready,
  output logic                frame_done,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                seg_dp
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PC_LAST  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

  // Active-high {g,f,e,d,c,b,a}; A..E are the calculator's status glyphs.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h40;
      4'hB:    decode = 7'h79;
      4'hC:    decode = 7'h50;
      4'hD:    decode = 7'h5C;
      4'hE:    decode = 7'h73;
      default: decode = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]       pc_q, pc_d;
  logic [IW-1:0]       idx_q, idx_d;
  buf_state_e          pend_state_q, pend_state_d;
  logic [4*DIGITS-1:0] pend_num_q, pend_num_d, act_num_q, act_num_d;
  logic [2:0]          pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   lit_an_q, lit_an_d, an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d, frame_done_q, frame_done_d;

  logic                tick, boundary;
  logic [3:0]          nibs [DIGITS];
  logic [DIGITS-1:0]   lz_mask;

  always_comb begin
    tick     = (pc_q == PC_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    pc_d     = tick ? '0 : pc_q + PW'(1);
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pend_state_d = pend_state_q;
    pend_num_d   = pend_num_q;
    pend_dp_d    = pend_dp_q;
    act_num_d    = act_num_q;
    act_dp_d     = act_dp_q;
    unique case (pend_state_q)
      BUF_EMPTY: if (load) begin
        pend_num_d   = num;
        pend_dp_d    = dp;
        pend_state_d = BUF_FULL;
      end
      BUF_FULL: if (boundary) begin
        act_num_d    = pend_num_q;
        act_dp_d     = pend_dp_q;
        pend_state_d = BUF_EMPTY;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) nibs[i] = act_num_q[4*i +: 4];
  end

  always_comb begin
    lz_mask = '0;
`ifdef DISP_LZ_BLANK_EN
    begin : g_lz
      logic zeros_above;
      zeros_above = 1'b1;
      // Walk down from the MSD; stop blanking at the first non-zero nibble.
      for (int i = DIGITS - 1; i > 0; i--) begin
        zeros_above = zeros_above && (nibs[i] == 4'h0);
        lz_mask[i]  = zeros_above && (i > int'(act_dp_q));
      end
    end
`endif
  end

  always_comb begin
    lit_an_d = lit_an_q;
    seg_d    = seg_q;
    seg_dp_d = seg_dp_q;
    if (tick) begin
      lit_an_d = ~(DIGITS'(1) << idx_q);
      seg_d    = lz_mask[idx_q] ? 7'h7F : ~decode(nibs[idx_q]);
      seg_dp_d = (3'(idx_q) != act_dp_q);
    end
    an_d         = blank ? '1 : lit_an_d;
    frame_done_d = boundary;
  end

  // NOTE: the frame buffers are a handful of flops, not a RAM, so they take
  // the reset like everything else and a reset discards any pending frame.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= '0;
      idx_q        <= '0;
      pend_state_q <= BUF_EMPTY;
      pend_num_q   <= '0;
      pend_dp_q    <= '0;
      act_num_q    <= '0;
      act_dp_q     <= '0;
      lit_an_q     <= '1;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      pend_state_q <= pend_state_d;
      pend_num_q   <= pend_num_d;
      pend_dp_q    <= pend_dp_d;
      act_num_q    <= act_num_d;
      act_dp_q     <= act_dp_d;
      lit_an_q     <= lit_an_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = (pend_state_q == BUF_EMPTY);
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan: directed scenarios plus randomized traffic
// checked against a frame-level reference model computed from the cycle count.
`timescale 1ns/1ps
module tb_disp_scan;
  localparam int DIGITS   = 8;
  localparam int PRESCALE = 4;
  localparam int FRAME    = DIGITS * PRESCALE;
  // Active-high gfedcba glyphs for nibbles 0..F.
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h79, 7'h50, 7'h5C, 7'h73, 7'h00};
  // Expected active-low seg for FEDC_BA98, digit 0 first.
  localparam logic [6:0] SEG_FEDC [8] = '{7'h00, 7'h10, 7'h3F, 7'h06, 7'h2F,
    7'h23, 7'h0C, 7'h7F};

  logic        clk = 1'b0, rst = 1'b0, load = 1'b0, blank = 1'b0;
  logic [31:0] num = '0;
  logic [2:0]  dp = '0;
  logic        ready, frame_done, seg_dp;
  logic [7:0]  an;
  logic [6:0]  seg;
  int          total = 0;
  int          bad = 0;

  disp_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .load(load), .num(num), .dp(dp), .blank(blank),
    .ready(ready), .frame_done(frame_done), .an(an), .seg(seg), .seg_dp(seg_dp)
  );

  always #5 clk = ~clk;

  // Reference model: k counts rising edges since reset release.
  int          k;
  logic [31:0] m_act_num, m_pend_num;
  logic [2:0]  m_act_dp, m_pend_dp;
  bit          m_pend_full;
  logic [7:0]  m_lit, e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  task automatic model_reset();
    k = 0; m_act_num = '0; m_pend_num = '0; m_act_dp = '0; m_pend_dp = '0;
    m_pend_full = 1'b0; m_lit = 8'hFF; e_an = 8'hFF; e_seg = 7'h7F;
    e_dp = 1'b1; e_fd = 1'b0;
  endtask

  // One rising edge: every PRESCALE-th edge lights digit (tick#-1) mod DIGITS,
  // every DIGITS-th tick ends a frame.
  task automatic step();
    int t, d;
    bit tick, boundary, lz;
    logic [3:0] nib;
    @(posedge clk);
    k++;
    tick = (k % PRESCALE) == 0;
    t = k / PRESCALE;
    boundary = tick && (t % DIGITS == 0);
    if (tick) begin
      d = (t - 1) % DIGITS;
      nib = 4'(m_act_num >> (4 * d));
      lz = 1'b0;
`ifdef DISP_LZ_BLANK_EN
      lz = (d > 0) && (d > int'(m_act_dp)) && ((m_act_num >> (4 * d)) == 32'h0);
`endif
      e_seg = lz ? 7'h7F : ~GLYPH[nib];
      e_dp = (d != int'(m_act_dp));
      m_lit = ~(8'h01 << d);
    end
    e_an = blank ? 8'hFF : m_lit;
    e_fd = boundary;
    if (boundary && m_pend_full) begin
      m_act_num = m_pend_num; m_act_dp = m_pend_dp; m_pend_full = 1'b0;
    end else if (load && !m_pend_full) begin
      m_pend_num = num; m_pend_dp = dp; m_pend_full = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    total++;
    if ({an, seg, seg_dp, ready, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got an=%h seg=%h dp=%b rdy=%b fd=%b, want ff 7f 1 1 0",
               an, seg, seg_dp, ready, frame_done);
    end
    #10 rst = 1'b1;
    for (int c = 1; c < PRESCALE; c++) begin
      step();
      total++;
      if (an !== 8'hFF || seg !== 7'h7F) begin
        bad++; $display("FAIL dark_after_release: got an=%h seg=%h, want ff 7f", an, seg);
      end
    end
    step();
    total++;
    if ({an, seg, ready} !== {8'hFE, 7'h40, 1'b1}) begin
      bad++; $display("FAIL first_digit: got an=%h seg=%h rdy=%b, want fe 40 1", an, seg, ready);
    end
  endtask

  task automatic test_load_handshake();
    bit found = 1'b0;
    num = 32'h0000_1234; dp = 3'd2; load = 1'b1;
    step();
    load = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ready_fall: got %b, want 0", ready); end
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL load_wait: got %h, want %h", {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
      if (frame_done === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || ready !== 1'b1) begin
      bad++; $display("FAIL ready_rise: got found=%b rdy=%b, want 1 1", found, ready);
    end
    for (int c = 0; c < FRAME; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL load_frame: got %h, want %h", {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
      if (an === 8'hFE) begin
        total++;
        if (seg !== 7'h19) begin bad++; $display("FAIL digit0_four: got %h, want 19", seg); end
      end
      if (an === 8'hFB) begin
        total++;
        if (seg !== 7'h24 || seg_dp !== 1'b0) begin
          bad++; $display("FAIL digit2_point: got seg=%h dp=%b, want 24 0", seg, seg_dp);
        end
      end
    end
  endtask

  task automatic test_ignored_load();
    bit found = 1'b0;
    num = 32'h0000_5678; dp = 3'd7; load = 1'b1;
    step();
    num = 32'h9999_9999; dp = 3'd0;
    repeat (3) step();
    load = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ignored_ready: got %b, want 0", ready); end
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL ignored_swap_timeout: got none, want frame_done"); end
    for (int c = 0; c < FRAME; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL ignored_frame: got %h, want %h", {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
      if (an === 8'hFE && seg !== 7'h00) begin
        bad++; $display("FAIL ignored_digit0: got %h, want 00", seg);
      end
    end
  endtask

  task automatic test_boundary_load();
    for (int c = 0; c < FRAME && (k % FRAME) != FRAME - 1; c++) step();
    total++;
    if (ready !== 1'b1 || (k % FRAME) != FRAME - 1) begin
      bad++; $display("FAIL boundary_setup: got rdy=%b phase=%0d, want 1 %0d", ready, k % FRAME, FRAME - 1);
    end
    num = 32'h0000_0003; dp = 3'd0; load = 1'b1;
    step();
    load = 1'b0;
    total++;
    if (frame_done !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL boundary_capture: got fd=%b rdy=%b, want 1 0", frame_done, ready);
    end
    for (int c = 1; c < FRAME; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL boundary_frame: got %h, want %h", {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
      if (an === 8'hFE && seg !== 7'h00) begin
        bad++; $display("FAIL boundary_old_value: got %h, want 00", seg);
      end
    end
    step();
    total++;
    if (frame_done !== 1'b1 || ready !== 1'b1) begin
      bad++; $display("FAIL cadence_32: got fd=%b rdy=%b, want 1 1", frame_done, ready);
    end
    repeat (PRESCALE) step();
    total++;
    if ({an, seg, seg_dp} !== {8'hFE, 7'h30, 1'b0}) begin
      bad++; $display("FAIL boundary_new_value: got an=%h seg=%h dp=%b, want fe 30 0", an, seg, seg_dp);
    end
  endtask

  task automatic test_glyphs();
    bit found = 1'b0;
    num = 32'hFEDC_BA98; dp = 3'd0; load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL glyph_swap_timeout: got none, want frame_done"); end
    for (int d = 0; d < DIGITS; d++) begin
      repeat (PRESCALE) step();
      total++;
      if ({an, seg, seg_dp} !== {~(8'h01 << d), SEG_FEDC[d], (d != 0)} ||
          {an, seg, seg_dp} !== {e_an, e_seg, e_dp}) begin
        bad++; $display("FAIL glyph_digit%0d: got an=%h seg=%h dp=%b, want %h %h %b", d, an, seg,
                        seg_dp, ~(8'h01 << d), SEG_FEDC[d], (d != 0));
      end
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    step();
    total++;
    if (an !== 8'hFF || seg !== e_seg) begin
      bad++; $display("FAIL blank_on: got an=%h seg=%h, want ff %h", an, seg, e_seg);
    end
    for (int c = 0; c < 2 * PRESCALE; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        bad++; $display("FAIL blank_hold: got %h, want %h", {an, seg, seg_dp, frame_done},
                        {e_an, e_seg, e_dp, e_fd});
      end
    end
    blank = 1'b0;
    step();
    total++;
    if (an !== e_an || an === 8'hFF) begin
      bad++; $display("FAIL blank_off: got an=%h, want %h", an, e_an);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      load  = ($urandom_range(3) == 0);
      blank = ($urandom_range(7) == 0);
      num   = $urandom() >> (4 * $urandom_range(7));
      dp    = 3'($urandom_range(7));
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL random k=%0d: got %h, want %h", k, {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
    end
    load = 1'b0; blank = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3 * FRAME && !((k % FRAME) == FRAME - 1 && !m_pend_full); c++) step();
    num = 32'h0000_4321; dp = 3'd1; load = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({frame_done, ready} !== 2'b10 || an === 8'hFF) begin
      bad++; $display("FAIL pre_reset_state: got fd=%b rdy=%b an=%h, want 1 0 lit", frame_done, ready, an);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({an, seg, seg_dp, ready, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL async_reset: got an=%h seg=%h dp=%b rdy=%b fd=%b, want ff 7f 1 1 0",
                      an, seg, seg_dp, ready, frame_done);
    end
    #2 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * FRAME + PRESCALE; c++) begin
      step();
      total++;
      if ({an, seg, seg_dp, ready, frame_done} !== {e_an, e_seg, e_dp, !m_pend_full, e_fd}) begin
        bad++; $display("FAIL post_reset: got %h, want %h", {an, seg, seg_dp, ready, frame_done},
                        {e_an, e_seg, e_dp, !m_pend_full, e_fd});
      end
    end
    total++;
    if ({an, seg} !== {8'hFE, 7'h40}) begin
      bad++; $display("FAIL pending_discarded: got an=%h seg=%h, want fe 40", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_load_handshake();
    test_ignored_load();
    test_boundary_load();
    test_glyphs();
    test_blank();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
